// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter with bounded lock
// in front of a single-port synchronous SRAM.
module sram_arbiter #(
  parameter int MDW      = 32,
  parameter int MAW      = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           m0_req,
  input  logic           m0_lock,
  input  logic           m0_wr,
  input  logic [MAW-1:0] m0_addr,
  input  logic [MDW-1:0] m0_wdata,
  input  logic [3:0]     m0_ben,
  output logic           m0_gnt,
  output logic           m0_rvalid,
  input  logic           m1_req,
  input  logic           m1_lock,
  input  logic           m1_wr,
  input  logic [MAW-1:0] m1_addr,
  input  logic [MDW-1:0] m1_wdata,
  input  logic [3:0]     m1_ben,
  output logic           m1_gnt,
  output logic           m1_rvalid,
  output logic [MDW-1:0] rdata,
  output logic           ramcs_n,
  output logic           ramwr_n,
  output logic [MAW-1:0] ramaddr,
  output logic [MDW-1:0] ramdin,
  output logic [3:0]     ramben,
  input  logic [MDW-1:0] ramdout
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] LMAX = 8'(MAX_LOCK);

  state_e     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;

  logic g0, g1, forced;
  logic wr_sel;

  // grant decision: round robin in ARB, owner priority with bounded lock
  always_comb begin
    g0     = 1'b0;
    g1     = 1'b0;
    forced = 1'b0;
    unique case (state_q)
      ARB: begin
        if (m0_req && m1_req) begin
          g0 = last_gnt_q;
          g1 = ~last_gnt_q;
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
      end
      OWN0: begin
        if (m1_req && lock_cnt_q == LMAX) begin
          g1     = 1'b1;
          forced = 1'b1;
        end else if (m0_req) begin
          g0 = 1'b1;
        end else begin
          g1 = m1_req;
        end
      end
      OWN1: begin
        if (m0_req && lock_cnt_q == LMAX) begin
          g0     = 1'b1;
          forced = 1'b1;
        end else if (m1_req) begin
          g1 = 1'b1;
        end else begin
          g0 = m0_req;
        end
      end
      default: begin
        g0 = 1'b0;
        g1 = 1'b0;
      end
    endcase
    if (!rst_n) begin
      g0     = 1'b0;
      g1     = 1'b0;
      forced = 1'b0;
    end
  end

  // SRAM pin mux driven from the granted master
  always_comb begin
    wr_sel  = g1 ? m1_wr : m0_wr;
    m0_gnt  = g0;
    m1_gnt  = g1;
    ramcs_n = ~(g0 | g1);
    ramwr_n = ~((g0 | g1) & wr_sel);
    ramaddr = '0;
    ramdin  = '0;
    ramben  = '0;
    if (rst_n) begin
      ramaddr = g1 ? m1_addr : m0_addr;
      ramdin  = g1 ? m1_wdata : m0_wdata;
      ramben  = wr_sel ? (g1 ? m1_ben : m0_ben) : 4'hF;
    end
  end

  assign rdata     = ramdout;
  assign m0_rvalid = rv0_q;
  assign m1_rvalid = rv1_q;

  // next-state: ownership, lock counter, round-robin pointer, read return
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    rv0_d      = g0 & ~m0_wr;
    rv1_d      = g1 & ~m1_wr;
    if (g0 | g1) last_gnt_d = g1;
    unique case (state_q)
      ARB: begin
        if (g0 && m0_lock) begin
          state_d    = OWN0;
          lock_cnt_d = 8'd1;
        end else if (g1 && m1_lock) begin
          state_d    = OWN1;
          lock_cnt_d = 8'd1;
        end
      end
      OWN0: begin
        if (g0) begin
          if (m0_lock) begin
            if (!m1_req)               lock_cnt_d = 8'd1;
            else if (lock_cnt_q < LMAX) lock_cnt_d = lock_cnt_q + 8'd1;
            else                        lock_cnt_d = LMAX;
          end else begin
            state_d    = ARB;
            lock_cnt_d = 8'd0;
          end
        end else if (forced) begin
          state_d    = ARB;
          lock_cnt_d = 8'd0;
        end
      end
      OWN1: begin
        if (g1) begin
          if (m1_lock) begin
            if (!m0_req)               lock_cnt_d = 8'd1;
            else if (lock_cnt_q < LMAX) lock_cnt_d = lock_cnt_q + 8'd1;
            else                        lock_cnt_d = LMAX;
          end else begin
            state_d    = ARB;
            lock_cnt_d = 8'd0;
          end
        end else if (forced) begin
          state_d    = ARB;
          lock_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= 8'd0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against an
// owner/run-length reference model and a word SRAM.
module tb_sram_arbiter;

  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req[2], lock[2], wr[2];
  logic [31:0] addr[2], wdata[2];
  logic [3:0]  ben[2];
  logic        n_req[2], n_lock[2], n_wr[2];
  logic [31:0] n_addr[2], n_wdata[2];
  logic [3:0]  n_ben[2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] rdata, ramaddr, ramdin, ramdout;
  logic        ramcs_n, ramwr_n;
  logic [3:0]  ramben;

  logic [31:0] smem[16];
  logic [31:0] rmem[16];

  int total = 0;
  int bad = 0;

  int owner, run, last, g;
  logic erv0, erv1;
  logic [31:0] erd;
  logic pend[2];

  always #5 clk = ~clk;

  sram_arbiter #(.MDW(32), .MAW(32), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(req[0]), .m0_lock(lock[0]), .m0_wr(wr[0]),
    .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_ben(ben[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m1_req(req[1]), .m1_lock(lock[1]), .m1_wr(wr[1]),
    .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_ben(ben[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .ramcs_n(ramcs_n), .ramwr_n(ramwr_n),
    .ramaddr(ramaddr), .ramdin(ramdin), .ramben(ramben),
    .ramdout(ramdout)
  );

  // SRAM model: pins latched mid-cycle, applied on the rising edge
  initial begin
    logic s_cs, s_wr;
    logic [3:0] s_idx, s_ben;
    logic [31:0] s_din;
    ramdout = '0;
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      rmem[i] = smem[i];
    end
    smem[4] = 32'hCAFE0001;
    rmem[4] = 32'hCAFE0001;
    forever begin
      @(negedge clk);
      #2;
      s_cs  = ~ramcs_n;
      s_wr  = ~ramwr_n;
      s_idx = ramaddr[5:2];
      s_ben = ramben;
      s_din = ramdin;
      @(posedge clk);
      if (s_cs && rst_n) begin
        if (s_wr) begin
          for (int b = 0; b < 4; b++)
            if (s_ben[b]) smem[s_idx][8*b+:8] = s_din[8*b+:8];
        end else begin
          ramdout = smem[s_idx];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic setm(input int m, input logic r, input logic l,
                      input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b);
    n_req[m] = r; n_lock[m] = l; n_wr[m] = w;
    n_addr[m] = a; n_wdata[m] = d; n_ben[m] = b;
  endtask

  task automatic model_reset();
    owner = -1; run = 0; last = 1;
    erv0 = 1'b0; erv1 = 1'b0;
  endtask

  task automatic step();
    int t;
    logic forced_m;
    logic [3:0] idx;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      req[m] = n_req[m]; lock[m] = n_lock[m]; wr[m] = n_wr[m];
      addr[m] = n_addr[m]; wdata[m] = n_wdata[m]; ben[m] = n_ben[m];
    end
    #1;
    chk("rvalid0", m0_rvalid, erv0);
    chk("rvalid1", m1_rvalid, erv1);
    if (erv0 || erv1) chk("rdata", rdata, erd);
    forced_m = 1'b0;
    if (owner < 0) begin
      if (req[0] && req[1]) g = 1 - last;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
      else g = -1;
    end else begin
      t = 1 - owner;
      if (req[t] && run == MAXL) begin g = t; forced_m = 1'b1; end
      else if (req[owner]) g = owner;
      else if (req[t]) g = t;
      else g = -1;
    end
    chk("gnt0", m0_gnt, g == 0);
    chk("gnt1", m1_gnt, g == 1);
    chk("cs_n", ramcs_n, g < 0);
    erv0 = 1'b0;
    erv1 = 1'b0;
    if (g >= 0) begin
      chk("wr_n", ramwr_n, !wr[g]);
      chk("addr", ramaddr, addr[g]);
      chk("ben", ramben, wr[g] ? ben[g] : 4'hF);
      idx = addr[g][5:2];
      if (wr[g]) begin
        chk("din", ramdin, wdata[g]);
        for (int b = 0; b < 4; b++)
          if (ben[g][b]) rmem[idx][8*b+:8] = wdata[g][8*b+:8];
      end else begin
        erd = rmem[idx];
        if (g == 0) erv0 = 1'b1; else erv1 = 1'b1;
      end
      last = g;
      if (owner < 0) begin
        if (lock[g]) begin owner = g; run = 1; end
      end else if (g == owner) begin
        if (!lock[g]) begin owner = -1; run = 0; end
        else if (!req[1-g]) run = 1;
        else if (run < MAXL) run++;
      end else if (forced_m) begin
        owner = -1; run = 0;
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      setm(m, 0, 0, 0, 0, 0, 0);
      req[m] = 0; lock[m] = 0; wr[m] = 0;
      addr[m] = 0; wdata[m] = 0; ben[m] = 0;
      pend[m] = 0;
    end
    model_reset();
    #1;
    chk("rst_cs_n", ramcs_n, 1'b1);
    chk("rst_addr", ramaddr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single read of word 4, twice, then reset mid-read
    setm(0, 1, 0, 0, 32'h10, 0, 0);
    step();
    step();
    chk("t2_rdata", rdata, 32'hCAFE0001);
    rst_n = 1'b0;
    #1;
    chk("t1_cs_n", ramcs_n, 1'b1);
    chk("t1_rvalid", m0_rvalid, 1'b0);
    chk("t1_gnt", m0_gnt, 1'b0);
    req[0] = 0;
    setm(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // contention: alternating reads
    setm(0, 1, 0, 0, 32'h10, 0, 0);
    setm(1, 1, 0, 0, 32'h4, 0, 0);
    repeat (5) step();

    // byte write then readback
    setm(0, 0, 0, 0, 0, 0, 0);
    setm(1, 1, 0, 1, 32'h8, 32'h11223344, 4'b0011);
    step();
    setm(1, 1, 0, 0, 32'h8, 0, 0);
    step();
    setm(1, 0, 0, 0, 0, 0, 0);
    step();

    // lock bound with continuous contention
    setm(0, 1, 1, 0, 32'h10, 0, 0);
    setm(1, 1, 0, 0, 32'h20, 0, 0);
    repeat (8) step();
    setm(0, 1, 0, 0, 32'h10, 0, 0);
    setm(1, 0, 0, 0, 0, 0, 0);
    repeat (2) step();

    // owner idle gap
    setm(0, 1, 1, 1, 32'h30, 32'hA5A5A5A5, 4'hF);
    step();
    setm(0, 0, 1, 0, 32'h30, 0, 0);
    setm(1, 1, 0, 0, 32'h30, 0, 0);
    step();
    setm(0, 1, 1, 0, 32'h30, 0, 0);
    step();
    step();
    setm(0, 1, 0, 0, 32'h30, 0, 0);
    setm(1, 0, 0, 0, 0, 0, 0);
    step();

    // random traffic, requests held until granted
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m])
          setm(m, ($urandom % 4) != 0, $urandom % 2, $urandom % 2,
               32'($urandom_range(0, 15)) << 2, $urandom,
               4'($urandom));
      end
      step();
      for (int m = 0; m < 2; m++)
        pend[m] = req[m] && (g != m);
    end

    setm(0, 0, 0, 0, 0, 0, 0);
    setm(1, 0, 0, 0, 0, 0, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
